// File: rtl/line_seq_ctrl_pkg.sv
// Shared types and constants for the line sequencer: state encodings,
// header layout and field widths.
package line_seq_ctrl_pkg;

  localparam int         LINE_BYTES_DEF = 50;
  localparam logic [7:0] MARKER_DEF     = 8'hAA;
  localparam int         GAP_CYCLES_DEF = 100;
  localparam int         SUM_W_DEF      = 64;

  localparam int LEN_W     = 8;   // line_len / payload byte counter
  localparam int CNT_W     = 12;  // lines per job
  localparam int HDR_BYTES = 4;

  // header byte offsets
  localparam logic [1:0] HDR_MARK   = 2'd0;
  localparam logic [1:0] HDR_LEN    = 2'd1;
  localparam logic [1:0] HDR_CNT_HI = 2'd2;
  localparam logic [1:0] HDR_CNT_LO = 2'd3;

  // top-level sequencer; ST_SEND covers the whole serializer run
  typedef enum logic [2:0] {
    ST_HDR, ST_LOAD, ST_ISSUE, ST_WAITV, ST_SEND, ST_GAP
  } seq_state_e;

  // byte engine inside sum_serializer
  typedef enum logic [1:0] {
    SER_IDLE, SER_SEND, SER_PULSE, SER_HOLD
  } ser_state_e;

  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/sum_serializer.sv
// Sends a latched SUM_W-bit value MSB byte first through a ready/strobe
// transmitter; one-cycle done pulse once the last byte has been taken.
module sum_serializer
  import line_seq_ctrl_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] sum,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_xmit,
  output logic             done
);

  localparam int NB    = SUM_W / 8;
  localparam int IDX_W = $clog2(NB);

  ser_state_e       state, state_nxt;
  logic [SUM_W-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             last;

  assign last = (idx == IDX_W'(NB - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      SER_IDLE:  if (start) state_nxt = SER_SEND;
      SER_SEND:  if (tx_ready) state_nxt = SER_PULSE;
      SER_PULSE: state_nxt = SER_HOLD;
      // the transmitter must show busy before the next byte is offered
      SER_HOLD: if (!tx_ready) begin
        state_nxt = last ? SER_IDLE : SER_SEND;
        done      = last;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg   <= '0;
      idx     <= '0;
      tx_data <= '0;
      tx_xmit <= 1'b0;
    end else begin
      tx_xmit <= 1'b0;
      case (state)
        SER_IDLE: if (start) begin
          shreg <= sum;
          idx   <= '0;
        end
        SER_SEND: if (tx_ready) begin
          tx_data <= shreg[SUM_W-1 -: 8];
          shreg   <= shreg << 8;
          tx_xmit <= 1'b1;
        end
        SER_HOLD: if (!tx_ready && !last) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end

endmodule

// File: rtl/line_seq_ctrl.sv
// Job sequencer: parses the header, assembles BCD lines for the digit engine,
// accumulates per-line results and streams the sum back out.
module line_seq_ctrl
  import line_seq_ctrl_pkg::*;
#(
  parameter int         LINE_BYTES = LINE_BYTES_DEF,
  parameter logic [7:0] MARKER     = MARKER_DEF,
  parameter int         GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int         SUM_W      = SUM_W_DEF
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_recd,
  input  logic                    rx_par_ok,
  output logic                    rx_clr,
  output logic [8*LINE_BYTES-1:0] line_data,
  output logic [7:0]              line_len,
  output logic [3:0]              n_digits,
  output logic                    line_valid,
  input  logic                    line_ready,
  input  logic [SUM_W-1:0]        val_data,
  input  logic                    val_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_xmit,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int LD_W  = 8 * LINE_BYTES;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_e       state, state_nxt;
  logic [1:0]       hdr_idx;
  logic [LEN_W-1:0] byte_cnt;
  logic [CNT_W-1:0] count, hdr_count, count_dec;
  logic [SUM_W-1:0] sum;
  logic [GAP_W-1:0] gap_cnt;

  logic rx_state, consume, stray, marker_ok, hdr_done, hdr_bad;
  logic load_done, val_take, gap_done, err_set;
  logic ser_start, ser_go, ser_done;

  assign rx_state  = (state == ST_HDR) || (state == ST_LOAD);
  // rx_clr high means the previous byte is still being acknowledged
  assign consume   = rx_recd && !rx_clr && rx_state;
  assign stray     = rx_recd && !rx_state;
  assign marker_ok = consume && (state == ST_HDR) && (hdr_idx == HDR_MARK) && (rx_data == MARKER);
  assign hdr_count = {count[CNT_W-1:4], rx_data[7:4]};
  assign hdr_done  = consume && (state == ST_HDR) && (hdr_idx == HDR_CNT_LO);
  assign hdr_bad   = !len_ok(line_len, LINE_BYTES);
  assign load_done = consume && (state == ST_LOAD) && (byte_cnt + LEN_W'(1) == line_len);
  assign val_take  = val_valid && (state == ST_WAITV);
  assign count_dec = count - CNT_W'(1);
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign err_set   = stray || (consume && !rx_par_ok) || (hdr_done && hdr_bad);
  assign busy      = (state != ST_HDR);

  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) state <= ST_HDR;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    ser_start = 1'b0;
    case (state)
      ST_HDR: if (hdr_done && !hdr_bad) begin
        if (hdr_count == '0) begin
          state_nxt = ST_SEND;
          ser_start = 1'b1;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (load_done) state_nxt = ST_ISSUE;
      ST_ISSUE: if (line_ready) state_nxt = ST_WAITV;
      ST_WAITV: if (val_take) begin
        if (count_dec == '0) begin
          state_nxt = ST_SEND;
          ser_start = 1'b1;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_SEND: if (ser_done) state_nxt = ST_GAP;
      ST_GAP:  if (gap_done) state_nxt = ST_HDR;
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      hdr_idx    <= HDR_MARK;
      byte_cnt   <= '0;
      count      <= '0;
      sum        <= '0;
      gap_cnt    <= '0;
      ser_go     <= 1'b0;
      rx_clr     <= 1'b0;
      line_data  <= '0;
      line_len   <= '0;
      n_digits   <= '0;
      line_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_clr <= consume;
      // start is delayed a cycle so the serializer latches the final sum
      ser_go <= ser_start;
      err    <= err_set || (err && !marker_ok);

      if (consume && state == ST_HDR) begin
        case (hdr_idx)
          HDR_MARK: if (rx_data == MARKER) hdr_idx <= HDR_LEN;
          HDR_LEN: begin
            line_len <= rx_data;
            hdr_idx  <= HDR_CNT_HI;
          end
          HDR_CNT_HI: begin
            count[CNT_W-1:4] <= rx_data;
            hdr_idx          <= HDR_CNT_LO;
          end
          default: begin
            count    <= hdr_count;
            n_digits <= rx_data[3:0];
            hdr_idx  <= HDR_MARK;
            if (!hdr_bad && hdr_count != '0) begin
              line_data <= '0;
              byte_cnt  <= '0;
            end
          end
        endcase
      end

      if (consume && state == ST_LOAD) begin
        line_data <= {line_data[LD_W-9:0], rx_data};
        byte_cnt  <= byte_cnt + LEN_W'(1);
        if (load_done) line_valid <= 1'b1;
      end

      if (state == ST_ISSUE && line_ready) line_valid <= 1'b0;

      if (val_take) begin
        sum   <= sum + val_data;
        count <= count_dec;
        if (count_dec != '0) begin
          line_data <= '0;
          byte_cnt  <= '0;
        end
      end

      if (state == ST_GAP) begin
        gap_cnt <= gap_done ? '0 : gap_cnt + GAP_W'(1);
        if (gap_done) sum <= '0;
      end
    end

  sum_serializer #(.SUM_W(SUM_W)) u_ser (
    .clk      (sysclk),
    .rst_n    (rst_n),
    .start    (ser_go),
    .sum      (sum),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_xmit  (tx_xmit),
    .done     (ser_done)
  );

endmodule
